// File: rtl/spike_stream_packer.sv
// Packs eight 8-channel spike beats into 64-bit words behind a small FWFT FIFO,
// with a frame-end flush that emits a zero-padded last word and reports drain completion.
module spike_stream_packer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int BEATS_PER_WORD = 8
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [7:0]  ch0_data_i,
    input  logic [7:0]  ch1_data_i,
    input  logic [7:0]  ch2_data_i,
    input  logic [7:0]  ch3_data_i,
    input  logic [7:0]  ch4_data_i,
    input  logic [7:0]  ch5_data_i,
    input  logic [7:0]  ch6_data_i,
    input  logic [7:0]  ch7_data_i,
    input  logic        ch_data_vld_i,
    input  logic        flush_i,
    output logic [63:0] stream_tx_data,
    output logic        stream_tx_last,
    output logic        stream_tx_vld,
    input  logic        stream_tx_rdy,
    output logic        flush_done_o,
    output logic        overflow_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BEATS_PER_WORD);

    typedef enum logic [1:0] {S_PACK, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [63:0]         pack_q, pack_d, pack_ins;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic                ovf_q, ovf_set;
    logic [64:0]         mem_q [FIFO_DEPTH];
    logic [64:0]         head;
    logic [7:0]          beat;
    logic                push, push_last, push_ok, pop, full;
    logic [63:0]         push_data;
    logic                unused_ch_bits;

    assign beat = {ch7_data_i[0], ch6_data_i[0], ch5_data_i[0], ch4_data_i[0],
                   ch3_data_i[0], ch2_data_i[0], ch1_data_i[0], ch0_data_i[0]};
    assign unused_ch_bits = ^{ch0_data_i[7:1], ch1_data_i[7:1], ch2_data_i[7:1], ch3_data_i[7:1],
                              ch4_data_i[7:1], ch5_data_i[7:1], ch6_data_i[7:1], ch7_data_i[7:1]};

    always_comb begin
        state_d   = state_q;
        pack_d    = pack_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_last = 1'b0;
        push_data = pack_q;
        ovf_set   = 1'b0;
        pack_ins  = pack_q;
        if (ch_data_vld_i)
            pack_ins[{cnt_q, 3'b000} +: 8] = beat;

        case (state_q)
            S_PACK: begin
                if (flush_i) begin
                    // A same-cycle beat is folded in before the tail word is emitted.
                    push      = ch_data_vld_i || (cnt_q != '0);
                    push_last = 1'b1;
                    push_data = pack_ins;
                    pack_d    = '0;
                    cnt_d     = '0;
                    state_d   = S_DRAIN;
                end else if (ch_data_vld_i) begin
                    if (cnt_q == BEAT_W'(BEATS_PER_WORD - 1)) begin
                        push      = 1'b1;
                        push_data = pack_ins;
                        pack_d    = '0;
                        cnt_d     = '0;
                    end else begin
                        pack_d = pack_ins;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                ovf_set = ch_data_vld_i;
                if (count_q == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                ovf_set = ch_data_vld_i;
                pack_d  = '0;
                cnt_d   = '0;
                state_d = S_PACK;
            end
            default: state_d = S_PACK;
        endcase

        pop     = (count_q != '0) && stream_tx_rdy;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        // A full FIFO still accepts a push when its head leaves on the same edge.
        push_ok = push && (!full || pop);
        if (push && !push_ok)
            ovf_set = 1'b1;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q  <= S_PACK;
            pack_q   <= '0;
            cnt_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pack_q  <= pack_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ovf_set) ovf_q    <= 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {push_last, push_data};
    end

    // Head is masked while empty so stale storage never shows on the port.
    assign head           = stream_tx_vld ? mem_q[rd_ptr_q] : '0;
    assign stream_tx_vld  = (count_q != '0);
    assign stream_tx_data = head[63:0];
    assign stream_tx_last = head[64];
    assign flush_done_o   = (state_q == S_DONE);
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_spike_stream_packer.sv
// Randomized and directed bench for spike_stream_packer against a queue-based
// transaction model of beat packing, flush framing and FIFO buffering.
module tb_spike_stream_packer;
    localparam int DEPTH = 4;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic [7:0]  ch [8];
    logic        vld_i = 1'b0, flush = 1'b0, rdy = 1'b0;
    logic [63:0] stream_tx_data;
    logic        stream_tx_last, stream_tx_vld, flush_done_o, overflow_o;

    int n_chk = 0, n_fail = 0;

    // Model: beats of the word being built, words awaiting transfer, and frame phase.
    logic [7:0]  bq [$];
    logic [64:0] mq [$];
    int          mode = 0;   // 0 packing, 1 draining, 2 done pulse
    bit          m_ovf = 1'b0;

    always #5 sclk = ~sclk;

    spike_stream_packer #(.FIFO_DEPTH(DEPTH), .BEATS_PER_WORD(8)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .ch0_data_i(ch[0]), .ch1_data_i(ch[1]), .ch2_data_i(ch[2]), .ch3_data_i(ch[3]),
        .ch4_data_i(ch[4]), .ch5_data_i(ch[5]), .ch6_data_i(ch[6]), .ch7_data_i(ch[7]),
        .ch_data_vld_i(vld_i), .flush_i(flush),
        .stream_tx_data(stream_tx_data), .stream_tx_last(stream_tx_last),
        .stream_tx_vld(stream_tx_vld), .stream_tx_rdy(rdy),
        .flush_done_o(flush_done_o), .overflow_o(overflow_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_of_beats();
        logic [63:0] w = '0;
        for (int k = 0; k < bq.size(); k++)
            w += 64'(bq[k]) * (64'd1 << (8 * k));
        return w;
    endfunction

    task automatic model_check();
        chk("vld", {63'd0, stream_tx_vld}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("data", stream_tx_data, mq[0][63:0]);
            chk("last", {63'd0, stream_tx_last}, {63'd0, mq[0][64]});
        end
        chk("flush_done", {63'd0, flush_done_o}, {63'd0, mode == 2});
        chk("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
    endtask

    task automatic model_edge(input logic [7:0] b, input bit v, input bit f, input bit r);
        logic [64:0] pw = '0;
        bit push = 1'b0;
        int pre = mq.size();
        case (mode)
            0: begin
                if (v) bq.push_back(b);
                if (f) begin
                    if (bq.size() > 0) begin push = 1'b1; pw = {1'b1, word_of_beats()}; end
                    bq.delete();
                    mode = 1;
                end else if (bq.size() == 8) begin
                    push = 1'b1; pw = {1'b0, word_of_beats()};
                    bq.delete();
                end
            end
            1: begin
                if (v) m_ovf = 1'b1;
                if (pre == 0) mode = 2;
            end
            default: begin
                if (v) m_ovf = 1'b1;
                mode = 0;
            end
        endcase
        if (pre > 0 && r) void'(mq.pop_front());
        if (push) begin
            if (pre < DEPTH || (pre > 0 && r)) mq.push_back(pw);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic [7:0] b, input bit v, input bit f, input bit r);
        @(negedge sclk);
        for (int c = 0; c < 8; c++) ch[c] = {7'($urandom), b[c]};
        vld_i = v; flush = f; rdy = r;
        #1;
        model_check();
        model_edge(b, v, f, r);
        @(posedge sclk);
        #2;
    endtask

    task automatic do_reset();
        vld_i = 1'b0; flush = 1'b0;
        #1 s_rst_n = 1'b0;
        #1;
        chk("rst_vld",  {63'd0, stream_tx_vld}, 64'd0);
        chk("rst_data", stream_tx_data, 64'd0);
        chk("rst_last", {63'd0, stream_tx_last}, 64'd0);
        chk("rst_done", {63'd0, flush_done_o}, 64'd0);
        chk("rst_ovf",  {63'd0, overflow_o}, 64'd0);
        bq.delete(); mq.delete(); mode = 0; m_ovf = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        s_rst_n = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 8; c++) ch[c] = 8'h00;
        do_reset();

        // Odd channels spiking for eight beats gives alternating bits.
        for (int i = 0; i < 8; i++) step(8'hAA, 1, 0, 1);
        chk("aa_vld",  {63'd0, stream_tx_vld}, 64'd1);
        chk("aa_word", stream_tx_data, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("aa_last", {63'd0, stream_tx_last}, 64'd0);
        step(8'h00, 0, 0, 1);

        // Partial word of three beats, then flush while stalled.
        step(8'h01, 1, 0, 1);
        step(8'h80, 1, 0, 1);
        step(8'hFF, 1, 0, 1);
        step(8'h00, 0, 1, 0);
        chk("part_word", stream_tx_data, 64'h0000_0000_00FF_8001);
        chk("part_last", {63'd0, stream_tx_last}, 64'd1);
        step(8'h00, 0, 0, 1);
        chk("part_done0", {63'd0, flush_done_o}, 64'd0);
        step(8'h00, 0, 0, 1);
        chk("part_done1", {63'd0, flush_done_o}, 64'd1);
        step(8'h00, 0, 0, 1);
        chk("part_done2", {63'd0, flush_done_o}, 64'd0);

        // Flush coincident with the eighth beat: one full word tagged last.
        for (int i = 0; i < 7; i++) step(8'($urandom), 1, 0, 1);
        step(8'h5A, 1, 1, 1);
        chk("full_last", {63'd0, stream_tx_last}, 64'd1);
        step(8'h00, 0, 0, 1);
        chk("full_noextra", {63'd0, stream_tx_vld}, 64'd0);
        for (int i = 0; i < 3; i++) step(8'h00, 0, 0, 1);

        // Flush with nothing packed and nothing buffered.
        step(8'h00, 0, 1, 1);
        chk("empty_fl_vld", {63'd0, stream_tx_vld}, 64'd0);
        chk("empty_fl_done0", {63'd0, flush_done_o}, 64'd0);
        step(8'h00, 0, 0, 1);
        chk("empty_fl_done1", {63'd0, flush_done_o}, 64'd1);
        step(8'h00, 0, 0, 1);

        // Five words into a stalled FIFO: fifth dropped, overflow sticks.
        for (int i = 0; i < 40; i++) step(8'($urandom), 1, 0, 0);
        chk("ovf_set", {63'd0, overflow_o}, 64'd1);
        for (int i = 0; i < 3; i++) step(8'h00, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(8'h00, 0, 0, 1);
        chk("ovf_sticky", {63'd0, overflow_o}, 64'd1);

        // Reset mid-word, then full FIFO with push and pop on the same edge.
        for (int i = 0; i < 3; i++) step(8'($urandom), 1, 0, 1);
        do_reset();
        for (int i = 0; i < 39; i++) step(8'($urandom), 1, 0, 0);
        step(8'($urandom), 1, 0, 1);
        chk("full_pp_ovf", {63'd0, overflow_o}, 64'd0);
        for (int i = 0; i < 6; i++) step(8'h00, 0, 0, 1);

        // Beat arriving while draining is dropped and flags overflow.
        for (int i = 0; i < 3; i++) step(8'($urandom), 1, 0, 0);
        step(8'h00, 0, 1, 0);
        step(8'h3C, 1, 0, 0);
        chk("drain_beat_ovf", {63'd0, overflow_o}, 64'd1);
        for (int i = 0; i < 4; i++) step(8'h00, 0, 0, 1);

        do_reset();
        for (int i = 0; i < 400; i++)
            step(8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 6);
        for (int i = 0; i < 20; i++) step(8'h00, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
